// File: rtl/pic_overlay_rd.sv
// Picture-in-picture read side: maps the HDMI raster onto a double-buffered
// picture RAM, swaps banks only at frame start and overlays the window on video.
module pic_overlay_rd #(
  parameter int          PIC_W      = 80,
  parameter int          PIC_H      = 80,
  parameter int          ADDR_W     = 16,
  parameter int          SCALE_LOG2 = 0,
  parameter bit          KEY_EN     = 1'b0,
  parameter logic [15:0] KEY_COLOR  = 16'hF81F
) (
  input  logic              hdmi_clk,
  input  logic              rst_n,
  input  logic              de,
  input  logic [11:0]       pic_x,
  input  logic [11:0]       pic_y,
  input  logic [15:0]       bg_pix,
  input  logic [11:0]       pos_x,
  input  logic [11:0]       pos_y,
  input  logic              swap_bytes,
  input  logic              bank_rdy_tgl,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_bank,
  input  logic [15:0]       ram_dout,
  output logic [15:0]       pix_out,
  output logic              de_out,
  output logic              swap_pulse,
  output logic              overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_RUN} state_t;

  localparam logic [12:0] WIN_W = 13'(PIC_W << SCALE_LOG2);
  localparam logic [12:0] WIN_H = 13'(PIC_H << SCALE_LOG2);

  state_t      state;
  logic        pending;
  logic [11:0] win_x, win_y;

  // S1: registered raster inputs
  logic        de_s1, swap_s1;
  logic [11:0] x_s1, y_s1, pos_x_s1, pos_y_s1;
  logic [15:0] bg_s1;

  // S2/S3: data travelling alongside the RAM access
  logic        de_s2, de_s3, win_s2, win_s3, swap_s2, swap_s3;
  logic [15:0] bg_s2, bg_s3;

  logic tgl_meta, tgl_sync, tgl_hist;

  logic              frame_start, rdy_edge, pend_next, do_swap, in_win, show_next;
  logic [11:0]       cur_x, cur_y;
  logic [12:0]       dx, dy;
  logic [ADDR_W-1:0] addr_calc;
  logic [15:0]       pic_word;
  logic              keyed;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    frame_start = de_s1 && (x_s1 == 12'd0) && (y_s1 == 12'd0);
    rdy_edge    = tgl_sync ^ tgl_hist;
    pend_next   = pending | rdy_edge;
    do_swap     = frame_start & pend_next;

    // The new window position applies from the frame-start pixel itself.
    cur_x = frame_start ? pos_x_s1 : win_x;
    cur_y = frame_start ? pos_y_s1 : win_y;

    // 13-bit compare: a window hanging off the right/bottom edge clips, never wraps.
    dx     = {1'b0, x_s1} - {1'b0, cur_x};
    dy     = {1'b0, y_s1} - {1'b0, cur_y};
    in_win = de_s1
          && (x_s1 >= cur_x) && ({1'b0, x_s1} < ({1'b0, cur_x} + WIN_W))
          && (y_s1 >= cur_y) && ({1'b0, y_s1} < ({1'b0, cur_y} + WIN_H));

    addr_calc = ADDR_W'(32'(dy >> SCALE_LOG2) * PIC_W + 32'(dx >> SCALE_LOG2));
    show_next = in_win && ((state == ST_RUN) || do_swap);

    pic_word = swap_s3 ? {ram_dout[7:0], ram_dout[15:8]} : ram_dout;
    keyed    = KEY_EN && (pic_word == KEY_COLOR);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      swap_pulse <= 1'b0;
      ram_bank   <= 1'b0;
      win_x      <= '0;
      win_y      <= '0;
    end else begin
      swap_pulse <= do_swap;
      if (frame_start) begin
        win_x <= pos_x_s1;
        win_y <= pos_y_s1;
      end
      if (do_swap) begin
        ram_bank <= ~ram_bank;
        pending  <= 1'b0;
      end else begin
        pending  <= pend_next;
      end
      // A second ready before the swap drops a frame; the bank flips only once.
      if (rdy_edge && pending && !frame_start)
        overrun <= 1'b1;

      case (state)
        ST_IDLE:  if (do_swap) state <= ST_RUN;
                  else if (pend_next) state <= ST_ARMED;
        ST_ARMED: if (do_swap) state <= ST_RUN;
        ST_RUN:   state <= ST_RUN;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: rst_n is synchronous and clears every flop here, including the whole
  // pipeline, so a reset mid-frame leaves nothing stale in flight.
  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      tgl_meta <= 1'b0;
      tgl_sync <= 1'b0;
      tgl_hist <= 1'b0;
      de_s1    <= 1'b0;
      swap_s1  <= 1'b0;
      x_s1     <= '0;
      y_s1     <= '0;
      pos_x_s1 <= '0;
      pos_y_s1 <= '0;
      bg_s1    <= '0;
      ram_addr <= '0;
      de_s2    <= 1'b0;
      win_s2   <= 1'b0;
      swap_s2  <= 1'b0;
      bg_s2    <= '0;
      de_s3    <= 1'b0;
      win_s3   <= 1'b0;
      swap_s3  <= 1'b0;
      bg_s3    <= '0;
      pix_out  <= '0;
      de_out   <= 1'b0;
    end else begin
      tgl_meta <= bank_rdy_tgl;
      tgl_sync <= tgl_meta;
      tgl_hist <= tgl_sync;

      de_s1    <= de;
      swap_s1  <= swap_bytes;
      x_s1     <= pic_x;
      y_s1     <= pic_y;
      pos_x_s1 <= pos_x;
      pos_y_s1 <= pos_y;
      bg_s1    <= bg_pix;

      if (in_win)
        ram_addr <= addr_calc;
      de_s2   <= de_s1;
      win_s2  <= show_next;
      swap_s2 <= swap_s1;
      bg_s2   <= bg_s1;

      de_s3   <= de_s2;
      win_s3  <= win_s2;
      swap_s3 <= swap_s2;
      bg_s3   <= bg_s2;

      pix_out <= (win_s3 && !keyed) ? pic_word : bg_s3;
      de_out  <= de_s3;
    end
  end

endmodule

// File: tb/tb_pic_overlay_rd.sv
// Directed bench for pic_overlay_rd: one unscaled keyed instance and one 2x
// instance share the raster stimulus, each with its own synchronous-read RAM.
module tb_pic_overlay_rd;

  logic        hdmi_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic        de       = 1'b0;
  logic [11:0] pic_x    = '0;
  logic [11:0] pic_y    = '0;
  logic [15:0] bg_pix   = '0;
  logic [11:0] pos_x    = '0;
  logic [11:0] pos_y    = '0;
  logic        swap_bytes   = 1'b0;
  logic        bank_rdy_tgl = 1'b0;

  logic [15:0] addr_a, addr_b, dout_a, dout_b, pix_a, pix_b;
  logic        bank_a, bank_b, de_a, de_b, sp_a, sp_b, ovr_a, ovr_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic sp_at, sp_next;

  always #5 hdmi_clk = ~hdmi_clk;

  pic_overlay_rd #(.PIC_W(80), .PIC_H(80), .ADDR_W(16), .SCALE_LOG2(0),
                   .KEY_EN(1'b1), .KEY_COLOR(16'hF81F)) u_dut (
    .hdmi_clk(hdmi_clk), .rst_n(rst_n), .de(de), .pic_x(pic_x), .pic_y(pic_y),
    .bg_pix(bg_pix), .pos_x(pos_x), .pos_y(pos_y), .swap_bytes(swap_bytes),
    .bank_rdy_tgl(bank_rdy_tgl), .ram_addr(addr_a), .ram_bank(bank_a),
    .ram_dout(dout_a), .pix_out(pix_a), .de_out(de_a), .swap_pulse(sp_a),
    .overrun(ovr_a)
  );

  pic_overlay_rd #(.PIC_W(80), .PIC_H(80), .ADDR_W(16), .SCALE_LOG2(1),
                   .KEY_EN(1'b0), .KEY_COLOR(16'hF81F)) u_dut_s (
    .hdmi_clk(hdmi_clk), .rst_n(rst_n), .de(de), .pic_x(pic_x), .pic_y(pic_y),
    .bg_pix(bg_pix), .pos_x(pos_x), .pos_y(pos_y), .swap_bytes(swap_bytes),
    .bank_rdy_tgl(bank_rdy_tgl), .ram_addr(addr_b), .ram_bank(bank_b),
    .ram_dout(dout_b), .pix_out(pix_b), .de_out(de_b), .swap_pulse(sp_b),
    .overrun(ovr_b)
  );

  // Picture content: bank 0 = 5000^addr, bank 1 = A000^addr, bank 1 word 100 = key colour.
  function automatic logic [15:0] ram_word(input logic bank, input logic [15:0] addr);
    if (bank && addr == 16'd100) return 16'hF81F;
    return (bank ? 16'hA000 : 16'h5000) ^ addr;
  endfunction

  always_ff @(posedge hdmi_clk) begin
    dout_a <= ram_word(bank_a, addr_a);
    dout_b <= ram_word(bank_b, addr_b);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One active pixel, then idle; returns once its result is at the outputs.
  task automatic drive_pix(input logic [11:0] x, input logic [11:0] y, input logic [15:0] bg);
    pic_x = x; pic_y = y; bg_pix = bg; de = 1'b1;
    @(posedge hdmi_clk); #1;
    de = 1'b0; bg_pix = 16'h0; pic_x = 12'd1; pic_y = 12'd1;
    repeat (3) @(posedge hdmi_clk);
    #1;
  endtask

  // Active pixel at (0,0); records swap_pulse one and two cycles later.
  task automatic frame();
    pic_x = 12'd0; pic_y = 12'd0; bg_pix = 16'h00F0; de = 1'b1;
    @(posedge hdmi_clk); #1;
    de = 1'b0; pic_x = 12'd1; pic_y = 12'd1;
    @(posedge hdmi_clk); #1;
    sp_at = sp_a;
    @(posedge hdmi_clk); #1;
    sp_next = sp_a;
    @(posedge hdmi_clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge hdmi_clk);
    #1;
    check("rst pix_out",  pix_a, 16'h0);
    check("rst de_out",   16'(de_a), 16'h0);
    check("rst ram_bank", 16'(bank_a), 16'h0);
    check("rst swap",     16'(sp_a), 16'h0);
    check("rst overrun",  16'(ovr_a), 16'h0);
    check("rst ram_addr", addr_a, 16'h0);
    rst_n = 1'b1;

    // No ready toggle: background everywhere, 4-cycle latency.
    pos_x = 12'd100; pos_y = 12'd50;
    frame();
    check("idle no swap", 16'(sp_at), 16'h0);
    pic_x = 12'd100; pic_y = 12'd50; bg_pix = 16'h1111; de = 1'b1;
    @(posedge hdmi_clk); #1;
    de = 1'b0; bg_pix = 16'h0;
    repeat (2) @(posedge hdmi_clk);
    #1;
    check("lat3 de_out", 16'(de_a), 16'h0);
    @(posedge hdmi_clk); #1;
    check("lat4 de_out",  16'(de_a), 16'h1);
    check("lat4 pix_out", pix_a, 16'h1111);
    @(posedge hdmi_clk); #1;
    check("lat5 de_out",  16'(de_a), 16'h0);
    check("idle bank",    16'(bank_a), 16'h0);

    // Toggle mid-frame: still background until the next frame start.
    bank_rdy_tgl = 1'b1;
    drive_pix(12'd120, 12'd60, 16'h2222);
    check("armed bg",   pix_a, 16'h2222);
    check("armed bank", 16'(bank_a), 16'h0);
    frame();
    check("swap at fs",    16'(sp_at), 16'h1);
    check("swap one-shot", 16'(sp_next), 16'h0);
    check("bank flipped",  16'(bank_a), 16'h1);
    check("bank flipped s", 16'(bank_b), 16'h1);

    drive_pix(12'd100, 12'd50, 16'h3333);
    check("win first word", pix_a, 16'hA000);
    drive_pix(12'd179, 12'd129, 16'h4444);
    check("win last word", pix_a, 16'hB8FF);
    drive_pix(12'd180, 12'd50, 16'h5555);
    check("right of win", pix_a, 16'h5555);
    drive_pix(12'd100, 12'd49, 16'h6666);
    check("above win", pix_a, 16'h6666);

    // Colour key, then byte-swapped output.
    drive_pix(12'd120, 12'd51, 16'h7777);
    check("key transparent", pix_a, 16'h7777);
    swap_bytes = 1'b1;
    drive_pix(12'd120, 12'd51, 16'h7777);
    check("key swapped", pix_a, 16'h1FF8);
    drive_pix(12'd101, 12'd50, 16'h8888);
    check("swap word1", pix_a, 16'h01A0);
    swap_bytes = 1'b0;

    // Two ready toggles in one frame: overrun, single flip.
    check("no overrun yet", 16'(ovr_a), 16'h0);
    bank_rdy_tgl = 1'b0;
    drive_pix(12'd1, 12'd2, 16'h0001);
    bank_rdy_tgl = 1'b1;
    drive_pix(12'd1, 12'd3, 16'h0002);
    check("overrun set",    16'(ovr_a), 16'h1);
    check("no midframe flip", 16'(bank_a), 16'h1);
    frame();
    check("ovr swap pulse", 16'(sp_at), 16'h1);
    check("ovr one flip",   16'(bank_a), 16'h0);
    frame();
    check("no second swap", 16'(sp_at), 16'h0);
    check("bank stays",     16'(bank_a), 16'h0);
    check("overrun sticky", 16'(ovr_a), 16'h1);
    drive_pix(12'd100, 12'd50, 16'h9999);
    check("bank0 word0", pix_a, 16'h5000);

    // 2x upscale instance at origin.
    pos_x = 12'd0; pos_y = 12'd0;
    frame();
    drive_pix(12'd0, 12'd0, 16'hB000);
    check("x2 (0,0)", pix_b, 16'h5000);
    drive_pix(12'd1, 12'd0, 16'hB001);
    check("x2 (1,0)", pix_b, 16'h5000);
    drive_pix(12'd0, 12'd1, 16'hB002);
    check("x2 (0,1)", pix_b, 16'h5000);
    drive_pix(12'd1, 12'd1, 16'hB003);
    check("x2 (1,1)", pix_b, 16'h5000);
    drive_pix(12'd2, 12'd0, 16'hB004);
    check("x2 (2,0)", pix_b, 16'h5001);
    drive_pix(12'd159, 12'd0, 16'hB005);
    check("x2 (159,0)", pix_b, 16'h504F);
    drive_pix(12'd160, 12'd0, 16'hB006);
    check("x2 (160,0)", pix_b, 16'hB006);
    drive_pix(12'd0, 12'd159, 16'hB007);
    check("x2 (0,159)", pix_b, 16'h48B0);
    drive_pix(12'd79, 12'd0, 16'hB008);
    check("x1 (79,0)", pix_a, 16'h504F);
    drive_pix(12'd80, 12'd0, 16'hB009);
    check("x1 (80,0)", pix_a, 16'hB009);

    // Window clipped at the bottom-right screen corner.
    pos_x = 12'd4090; pos_y = 12'd4090;
    frame();
    drive_pix(12'd4090, 12'd4090, 16'hC000);
    check("clip corner", pix_a, 16'h5000);
    drive_pix(12'd4095, 12'd4095, 16'hC001);
    check("clip last", pix_a, 16'h5195);
    check("clip last x2", pix_b, 16'h50A2);
    drive_pix(12'd5, 12'd4090, 16'hC002);
    check("no x wrap", pix_a, 16'hC002);
    drive_pix(12'd4092, 12'd10, 16'hC003);
    check("no y wrap", pix_a, 16'hC003);

    // Reset in the middle of a streaming window.
    pic_x = 12'd4091; pic_y = 12'd4091; bg_pix = 16'hD000; de = 1'b1;
    repeat (4) @(posedge hdmi_clk);
    #1;
    check("pre-rst de_out", 16'(de_a), 16'h1);
    rst_n = 1'b0; bank_rdy_tgl = 1'b0;
    @(posedge hdmi_clk); #1;
    check("mid-rst de_out",  16'(de_a), 16'h0);
    check("mid-rst pix_out", pix_a, 16'h0);
    check("mid-rst overrun", 16'(ovr_a), 16'h0);
    de = 1'b0;
    @(posedge hdmi_clk); #1;
    rst_n = 1'b1;
    frame();
    check("post-rst no swap", 16'(sp_at), 16'h0);
    drive_pix(12'd4090, 12'd4090, 16'hAAAA);
    check("post-rst idle bg", pix_a, 16'hAAAA);
    check("post-rst bank",    16'(bank_a), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
